// File: rtl/camellia_pkg.sv
// Camellia-128 subkey sequencer: shared constants, FSM state type and the
// per-subkey rotate/source/half lookup used by the selector.
package camellia_pkg;

  localparam int unsigned NUM_SK = 26;
  localparam int unsigned SK_W   = 64;
  localparam int unsigned POS_W  = 5;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_SK - 1);

  localparam logic [1:0] SK_KW = 2'b00;
  localparam logic [1:0] SK_K  = 2'b01;
  localparam logic [1:0] SK_KE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // One table row: which key is rotated, by how much, and which half is taken.
  typedef struct packed {
    logic       src_ka;
    logic [6:0] rot;
    logic       hi;
  } sk_entry_t;

  // Subkey id is the encryption-order position (kw1=0 ... kw4=25).
  function automatic sk_entry_t sk_lookup(input logic [POS_W-1:0] id);
    sk_entry_t e;
    e = '0;
    case (id)
      5'd0:    e = '{1'b0, 7'd0,   1'b1}; // kw1
      5'd1:    e = '{1'b0, 7'd0,   1'b0}; // kw2
      5'd2:    e = '{1'b1, 7'd0,   1'b1}; // k1
      5'd3:    e = '{1'b1, 7'd0,   1'b0}; // k2
      5'd4:    e = '{1'b0, 7'd15,  1'b1}; // k3
      5'd5:    e = '{1'b0, 7'd15,  1'b0}; // k4
      5'd6:    e = '{1'b1, 7'd15,  1'b1}; // k5
      5'd7:    e = '{1'b1, 7'd15,  1'b0}; // k6
      5'd8:    e = '{1'b1, 7'd30,  1'b1}; // ke1
      5'd9:    e = '{1'b1, 7'd30,  1'b0}; // ke2
      5'd10:   e = '{1'b0, 7'd45,  1'b1}; // k7
      5'd11:   e = '{1'b0, 7'd45,  1'b0}; // k8
      5'd12:   e = '{1'b1, 7'd45,  1'b1}; // k9
      5'd13:   e = '{1'b0, 7'd60,  1'b0}; // k10
      5'd14:   e = '{1'b1, 7'd60,  1'b1}; // k11
      5'd15:   e = '{1'b1, 7'd60,  1'b0}; // k12
      5'd16:   e = '{1'b0, 7'd77,  1'b1}; // ke3
      5'd17:   e = '{1'b0, 7'd77,  1'b0}; // ke4
      5'd18:   e = '{1'b0, 7'd94,  1'b1}; // k13
      5'd19:   e = '{1'b0, 7'd94,  1'b0}; // k14
      5'd20:   e = '{1'b1, 7'd94,  1'b1}; // k15
      5'd21:   e = '{1'b1, 7'd94,  1'b0}; // k16
      5'd22:   e = '{1'b0, 7'd111, 1'b1}; // k17
      5'd23:   e = '{1'b0, 7'd111, 1'b0}; // k18
      5'd24:   e = '{1'b1, 7'd111, 1'b1}; // kw3
      5'd25:   e = '{1'b1, 7'd111, 1'b0}; // kw4
      default: e = '0;
    endcase
    return e;
  endfunction

  // Decrypt order keeps kw pairs in-pair order but swaps the outer pairs;
  // everything between them is the exact reverse of the encrypt order.
  function automatic logic [POS_W-1:0] dec_to_enc(input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] id;
    if (pos < 5'd2)
      id = pos + 5'd24;
    else if (pos >= 5'd24)
      id = pos - 5'd24;
    else
      id = 5'd25 - pos;
    return id;
  endfunction

  // Type depends only on stream position and is the same in both orders.
  function automatic logic [1:0] sk_type(input logic [POS_W-1:0] pos);
    logic [1:0] t;
    case (pos)
      5'd0, 5'd1, 5'd24, 5'd25: t = SK_KW;
      5'd8, 5'd9, 5'd16, 5'd17: t = SK_KE;
      default:                  t = SK_K;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/camellia_subkey_select.sv
// Combinational subkey selector: (kl, ka, dir, pos) -> (subkey, type).
module camellia_subkey_select
  import camellia_pkg::*;
(
  input  logic [127:0]      i_kl,
  input  logic [127:0]      i_ka,
  input  logic              i_decrypt,
  input  logic [POS_W-1:0]  i_pos,
  output logic [SK_W-1:0]   o_sk,
  output logic [1:0]        o_sk_type
);

  logic [POS_W-1:0] w_id;
  sk_entry_t        w_ent;
  logic [127:0]     w_src;
  logic [255:0]     w_dbl;
  logic [127:0]     w_rot;

  // Map position to subkey id, rotate the chosen key and pick the half.
  always_comb begin
    w_id      = i_decrypt ? dec_to_enc(i_pos) : i_pos;
    w_ent     = sk_lookup(w_id);
    w_src     = w_ent.src_ka ? i_ka : i_kl;
    w_dbl     = {w_src, w_src} << w_ent.rot;
    w_rot     = w_dbl[255:128];
    o_sk      = w_ent.hi ? w_rot[127:64] : w_rot[63:0];
    o_sk_type = sk_type(i_pos);
  end

endmodule

// File: rtl/camellia_subkey_sequencer.sv
// Camellia-128 subkey sequencer: latches KL/KA on start and streams the 26
// subkeys over valid/ready in encrypt or decrypt order.
// Optional: CAMELLIA_KS_ZEROIZE_EN clears the key registers on entry to DONE.
module camellia_subkey_sequencer
  import camellia_pkg::*;
#(
  parameter bit IDLE_ZERO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_decrypt,
  input  logic [127:0]      i_kl,
  input  logic [127:0]      i_ka,
  output logic              o_busy,
  output logic              o_sk_valid,
  input  logic              i_sk_ready,
  output logic [SK_W-1:0]   o_sk,
  output logic [1:0]        o_sk_type,
  output logic [POS_W-1:0]  o_sk_idx,
  output logic              o_last,
  output logic              o_done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [127:0]     r_kl;
  logic [127:0]     r_ka;
  logic             r_dir;
  logic [POS_W-1:0] r_pos;
  logic [SK_W-1:0]  r_sk;
  logic [1:0]       r_type;

  logic             w_accept;
  logic             w_hs;
  logic             w_hs_last;
  logic             w_load;
  logic [127:0]     w_sel_kl;
  logic [127:0]     w_sel_ka;
  logic             w_sel_dir;
  logic [POS_W-1:0] w_sel_pos;
  logic [SK_W-1:0]  w_sk;
  logic [1:0]       w_type;
  logic             w_valid;

  // Start/handshake strobes and selector operands. On accept the selector
  // looks at the incoming keys directly so position 0 is ready next cycle.
  always_comb begin
    w_accept  = (r_state == ST_IDLE) && i_start;
    w_hs      = (r_state == ST_STREAM) && i_sk_ready;
    w_hs_last = w_hs && (r_pos == LAST_POS);
    w_load    = w_accept || (w_hs && !w_hs_last);
    w_sel_kl  = w_accept ? i_kl : r_kl;
    w_sel_ka  = w_accept ? i_ka : r_ka;
    w_sel_dir = w_accept ? i_decrypt : r_dir;
    w_sel_pos = w_accept ? '0 : r_pos + 5'd1;
  end

  camellia_subkey_select u_select (
    .i_kl      (w_sel_kl),
    .i_ka      (w_sel_ka),
    .i_decrypt (w_sel_dir),
    .i_pos     (w_sel_pos),
    .o_sk      (w_sk),
    .o_sk_type (w_type)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start)   w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_hs_last) w_state_nxt = ST_DONE;
      ST_DONE:                  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Key and direction latch, loaded only on an accepted start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_kl  <= '0;
      r_ka  <= '0;
      r_dir <= 1'b0;
    end else if (w_accept) begin
      r_kl  <= i_kl;
      r_ka  <= i_ka;
      r_dir <= i_decrypt;
    end
`ifdef CAMELLIA_KS_ZEROIZE_EN
    else if (w_hs_last) begin
      r_kl <= '0;
      r_ka <= '0;
    end
`endif
  end

  // Output registers: change only on start or a non-final handshake, so they
  // hold steady under backpressure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sk   <= '0;
      r_type <= '0;
      r_pos  <= '0;
    end else if (w_load) begin
      r_sk   <= w_sk;
      r_type <= w_type;
      r_pos  <= w_sel_pos;
    end
`ifdef CAMELLIA_KS_ZEROIZE_EN
    else if (w_hs_last && (IDLE_ZERO == 1'b0)) begin
      r_sk <= '0;
    end
`endif
  end

  // FSM outputs plus optional zero-masking of the data fields when idle.
  always_comb begin
    w_valid    = (r_state == ST_STREAM);
    o_sk_valid = w_valid;
    o_busy     = (r_state != ST_IDLE);
    o_done     = (r_state == ST_DONE);
    o_last     = w_valid && (r_pos == LAST_POS);
    o_sk       = r_sk;
    o_sk_type  = r_type;
    o_sk_idx   = r_pos;
    if (IDLE_ZERO && !w_valid) begin
      o_sk      = '0;
      o_sk_type = '0;
      o_sk_idx  = '0;
    end
  end

endmodule

// File: tb/tb_camellia_subkey_sequencer.sv
// Self-checking bench for camellia_subkey_sequencer: a named-subkey model
// builds the expected stream, a per-cycle monitor compares against it.
module tb_camellia_subkey_sequencer;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_decrypt = 1'b0;
  logic [127:0] i_kl = '0;
  logic [127:0] i_ka = '0;
  logic         i_sk_ready = 1'b1;
  logic         o_busy, o_sk_valid, o_last, o_done;
  logic [63:0]  o_sk;
  logic [1:0]   o_sk_type;
  logic [4:0]   o_sk_idx;

  int checks = 0;
  int errs   = 0;

  logic [63:0] exp_sk_q[$];
  logic [1:0]  exp_ty_q[$];

  int   mph = 0;      // model phase: 0 idle, 1 streaming, 2 done
  int   mpos = 0;
  int   mcyc = 0;
  int   hs = 0;
  int   test_id = 0;
  bit   pstall = 0;
  logic [63:0] psk;
  logic [4:0]  pidx;
  bit   bp_mode = 0;
  int   bp_i = 0;
  logic [3:0] bp_pat = 4'b1001;

  localparam logic [127:0] KL1 = {1'b1, 127'd0};
  localparam logic [127:0] KA1 = 128'd1;
  localparam logic [127:0] KLB = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] KAB = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] KLC = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
  localparam logic [127:0] KAC = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  camellia_subkey_sequencer #(.IDLE_ZERO(1'b1)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_decrypt  (i_decrypt),
    .i_kl       (i_kl),
    .i_ka       (i_ka),
    .o_busy     (o_busy),
    .o_sk_valid (o_sk_valid),
    .i_sk_ready (i_sk_ready),
    .o_sk       (o_sk),
    .o_sk_type  (o_sk_type),
    .o_sk_idx   (o_sk_idx),
    .o_last     (o_last),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rotl(input logic [127:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (128 - n));
  endfunction

  // Compute every named subkey, then lay them out in the requested order.
  task automatic build_model(input logic [127:0] kl, input logic [127:0] ka, input logic dec);
    logic [63:0]  kw [1:4];
    logic [63:0]  k  [1:18];
    logic [63:0]  ke [1:4];
    logic [127:0] t;
    t = rotl(kl, 0);   kw[1] = t[127:64]; kw[2] = t[63:0];
    t = rotl(ka, 0);   k[1]  = t[127:64]; k[2]  = t[63:0];
    t = rotl(kl, 15);  k[3]  = t[127:64]; k[4]  = t[63:0];
    t = rotl(ka, 15);  k[5]  = t[127:64]; k[6]  = t[63:0];
    t = rotl(ka, 30);  ke[1] = t[127:64]; ke[2] = t[63:0];
    t = rotl(kl, 45);  k[7]  = t[127:64]; k[8]  = t[63:0];
    t = rotl(ka, 45);  k[9]  = t[127:64];
    t = rotl(kl, 60);  k[10] = t[63:0];
    t = rotl(ka, 60);  k[11] = t[127:64]; k[12] = t[63:0];
    t = rotl(kl, 77);  ke[3] = t[127:64]; ke[4] = t[63:0];
    t = rotl(kl, 94);  k[13] = t[127:64]; k[14] = t[63:0];
    t = rotl(ka, 94);  k[15] = t[127:64]; k[16] = t[63:0];
    t = rotl(kl, 111); k[17] = t[127:64]; k[18] = t[63:0];
    t = rotl(ka, 111); kw[3] = t[127:64]; kw[4] = t[63:0];
    exp_sk_q.delete();
    exp_ty_q.delete();
    if (!dec) begin
      exp_sk_q.push_back(kw[1]); exp_ty_q.push_back(2'd0);
      exp_sk_q.push_back(kw[2]); exp_ty_q.push_back(2'd0);
      for (int i = 1; i <= 6; i++) begin exp_sk_q.push_back(k[i]); exp_ty_q.push_back(2'd1); end
      exp_sk_q.push_back(ke[1]); exp_ty_q.push_back(2'd2);
      exp_sk_q.push_back(ke[2]); exp_ty_q.push_back(2'd2);
      for (int i = 7; i <= 12; i++) begin exp_sk_q.push_back(k[i]); exp_ty_q.push_back(2'd1); end
      exp_sk_q.push_back(ke[3]); exp_ty_q.push_back(2'd2);
      exp_sk_q.push_back(ke[4]); exp_ty_q.push_back(2'd2);
      for (int i = 13; i <= 18; i++) begin exp_sk_q.push_back(k[i]); exp_ty_q.push_back(2'd1); end
      exp_sk_q.push_back(kw[3]); exp_ty_q.push_back(2'd0);
      exp_sk_q.push_back(kw[4]); exp_ty_q.push_back(2'd0);
    end else begin
      exp_sk_q.push_back(kw[3]); exp_ty_q.push_back(2'd0);
      exp_sk_q.push_back(kw[4]); exp_ty_q.push_back(2'd0);
      for (int i = 18; i >= 13; i--) begin exp_sk_q.push_back(k[i]); exp_ty_q.push_back(2'd1); end
      exp_sk_q.push_back(ke[4]); exp_ty_q.push_back(2'd2);
      exp_sk_q.push_back(ke[3]); exp_ty_q.push_back(2'd2);
      for (int i = 12; i >= 7; i--) begin exp_sk_q.push_back(k[i]); exp_ty_q.push_back(2'd1); end
      exp_sk_q.push_back(ke[2]); exp_ty_q.push_back(2'd2);
      exp_sk_q.push_back(ke[1]); exp_ty_q.push_back(2'd2);
      for (int i = 6; i >= 1; i--) begin exp_sk_q.push_back(k[i]); exp_ty_q.push_back(2'd1); end
      exp_sk_q.push_back(kw[1]); exp_ty_q.push_back(2'd0);
      exp_sk_q.push_back(kw[2]); exp_ty_q.push_back(2'd0);
    end
  endtask

  task automatic start_op(input logic [127:0] kl, input logic [127:0] ka, input logic dec);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_kl = kl; i_ka = ka; i_decrypt = dec;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge i_clk);
      if (o_done) seen = 1;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  task automatic wait_idx(input logic [4:0] target, input string nm);
    bit seen;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge i_clk); #1;
      if (o_sk_valid && o_sk_idx == target) seen = 1;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  initial begin
    fork
      // Per-cycle compare against the model, sampled on the falling edge.
      forever begin
        @(negedge i_clk);
        if (i_rst) begin
          chk("rst_valid", 64'(o_sk_valid), 64'd0);
          chk("rst_done",  64'(o_done),     64'd0);
          chk("rst_sk",    o_sk,            64'd0);
          mph = 0;
          pstall = 0;
        end else begin
          if (mph != 0) mcyc++;
          chk("valid", 64'(o_sk_valid), 64'(mph == 1));
          chk("busy",  64'(o_busy),     64'(mph != 0));
          chk("done",  64'(o_done),     64'(mph == 2));
          if (mph == 1) begin
            chk("idx",  64'(o_sk_idx),  64'(mpos));
            chk("sk",   o_sk,           exp_sk_q[mpos]);
            chk("type", 64'(o_sk_type), 64'(exp_ty_q[mpos]));
            chk("last", 64'(o_last),    64'(mpos == 25));
            if (pstall) begin
              chk("stall_sk",  o_sk,          psk);
              chk("stall_idx", 64'(o_sk_idx), 64'(pidx));
            end
            if (test_id == 1 && mpos == 0) chk("enc_kw1", o_sk, 64'h8000_0000_0000_0000);
            if (test_id == 1 && mpos == 3) chk("enc_k2",  o_sk, 64'h1);
            if (test_id == 1 && mpos == 5) chk("enc_k4",  o_sk, 64'h4000);
            if (test_id == 1 && mpos == 9) begin
              chk("enc_ke2",      o_sk,           64'h4000_0000);
              chk("enc_ke2_type", 64'(o_sk_type), 64'd2);
            end
            // KA=1 rotated by 111 puts the set bit at 111, bit 47 of the high half.
            if (test_id == 2 && mpos == 0)  chk("dec_kw3", o_sk, 64'h0000_8000_0000_0000);
            if (test_id == 2 && mpos == 24) chk("dec_kw1", o_sk, 64'h8000_0000_0000_0000);
            if (test_id == 2 && mpos == 25) begin
              chk("dec_kw2",  o_sk,        64'd0);
              chk("dec_last", 64'(o_last), 64'd1);
            end
            pstall = !i_sk_ready;
            psk = o_sk;
            pidx = o_sk_idx;
            if (i_sk_ready) hs++;
          end else begin
            pstall = 0;
            chk("idle_sk",   o_sk,           64'd0);
            chk("idle_idx",  64'(o_sk_idx),  64'd0);
            chk("idle_type", 64'(o_sk_type), 64'd0);
            chk("idle_last", 64'(o_last),    64'd0);
          end
          if (mph == 2) begin
            chk("handshakes", 64'(hs), 64'd26);
            if (test_id == 1) chk("done_cycle", 64'(mcyc), 64'd27);
          end
          case (mph)
            0: if (i_start) begin
                 build_model(i_kl, i_ka, i_decrypt);
                 mph = 1; mpos = 0; mcyc = 0; hs = 0;
               end
            1: if (i_sk_ready) begin
                 if (mpos == 25) mph = 2;
                 else mpos++;
               end
            default: mph = 0;
          endcase
        end
      end
      // Ready pattern generator for the backpressure case.
      forever begin
        @(posedge i_clk); #1;
        if (bp_mode) begin
          i_sk_ready = bp_pat[bp_i % 4];
          bp_i++;
        end
      end
    join_none

    // Reset state
    #3;
    chk("reset_valid", 64'(o_sk_valid), 64'd0);
    chk("reset_busy",  64'(o_busy),     64'd0);
    chk("reset_idx",   64'(o_sk_idx),   64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);

    // Encrypt, ready held high
    test_id = 1;
    start_op(KL1, KA1, 1'b0);
    wait_done(60, "enc_done_seen");

    // Decrypt, same keys
    test_id = 2;
    start_op(KL1, KA1, 1'b1);
    wait_done(60, "dec_done_seen");

    // Backpressure 1,0,0,1
    test_id = 3;
    bp_mode = 1;
    start_op(KLB, KAB, 1'b0);
    wait_done(200, "bp_done_seen");
    bp_mode = 0;
    #1 i_sk_ready = 1'b1;

    // Start while busy is ignored; keys changing mid-stream have no effect
    test_id = 4;
    start_op(KLB, KAB, 1'b1);
    wait_idx(5'd5, "restart_reach_pos5");
    i_start = 1'b1; i_kl = KLC; i_ka = KAC; i_decrypt = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(60, "restart_done_seen");
    start_op(KLC, KAC, 1'b0);
    wait_done(60, "newkeys_done_seen");

    // Start held through DONE: ignored in DONE, accepted in the following IDLE
    test_id = 5;
    #1;
    i_start = 1'b1; i_kl = KLB; i_ka = KAC; i_decrypt = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(60, "after_done_start_seen");

    // Reset mid-stream
    test_id = 6;
    start_op(KLC, KAB, 1'b0);
    wait_idx(5'd12, "reach_pos12");
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(o_sk_valid), 64'd0);
    chk("async_rst_busy",  64'(o_busy),     64'd0);
    chk("async_rst_sk",    o_sk,            64'd0);
    chk("async_rst_idx",   64'(o_sk_idx),   64'd0);
    chk("async_rst_type",  64'(o_sk_type),  64'd0);
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (4) @(posedge i_clk);
    start_op(KLC, KAB, 1'b1);
    wait_done(60, "post_rst_done_seen");

    // Key register contents after DONE
    @(posedge i_clk); #1;
`ifdef CAMELLIA_KS_ZEROIZE_EN
    chk("zeroize_kl_hi", dut.r_kl[127:64], 64'd0);
    chk("zeroize_ka_lo", dut.r_ka[63:0],   64'd0);
`else
    chk("retain_kl_hi", dut.r_kl[127:64], KLC[127:64]);
    chk("retain_ka_lo", dut.r_ka[63:0],   KAB[63:0]);
`endif

    repeat (3) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
